// File: rtl/axi_uart_bridge.sv
// AXI4 slave exposing a UART data/status register pair, with TX and RX byte
// FIFOs between the bus and the byte-level serial transmitter/receiver.
module axi_uart_bridge #(
    parameter logic [3:0]  DATA_OFS = 4'h8,
    parameter logic [3:0]  STAT_OFS = 4'hC,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [7:0]  ar_id,
    input  logic [31:0] ar_addr,
    input  logic [7:0]  ar_len,
    input  logic [2:0]  ar_size,
    input  logic [1:0]  ar_burst,
    input  logic        ar_valid,
    output logic        ar_ready,

    output logic [7:0]  r_id,
    output logic [1:0]  r_resp,
    output logic [31:0] r_data,
    output logic        r_last,
    output logic        r_valid,
    input  logic        r_ready,

    input  logic [7:0]  aw_id,
    input  logic [31:0] aw_addr,
    input  logic [7:0]  aw_len,
    input  logic [2:0]  aw_size,
    input  logic [1:0]  aw_burst,
    input  logic        aw_valid,
    output logic        aw_ready,

    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    input  logic        w_last,
    input  logic        w_valid,
    output logic        w_ready,

    output logic [7:0]  b_id,
    output logic [1:0]  b_resp,
    output logic        b_valid,
    input  logic        b_ready,

    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        rx_clear
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = TX_DEPTH[TX_AW:0];
    localparam logic [RX_AW:0] RX_FULL_CNT = RX_DEPTH[RX_AW:0];

    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    function automatic logic is_mapped(input logic [3:0] ofs);
        return (ofs == DATA_OFS) || (ofs == STAT_OFS);
    endfunction

    r_state_e        r_state_q, r_state_d;
    logic [7:0]      r_id_q, r_id_d;
    logic [31:0]     r_data_q, r_data_d;
    logic [1:0]      r_resp_q, r_resp_d;
    logic            r_last_q, r_last_d;
    logic            r_valid_q, r_valid_d;
    logic [7:0]      r_beats_q, r_beats_d;
    logic            rx_pop_pend_q, rx_pop_pend_d;

    w_state_e        w_state_q, w_state_d;
    logic [7:0]      w_id_q, w_id_d;
    logic [3:0]      w_ofs_q, w_ofs_d;

    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            rx_clear_q, rx_clear_d;

    logic [7:0]      tx_mem [TX_DEPTH];
    logic [7:0]      rx_mem [RX_DEPTH];
    logic [TX_AW:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_count;
    logic [RX_AW:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_count;
    logic            tx_push, tx_pop, tx_full, tx_empty;
    logic            rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]      tx_head, rx_head;

    // Wrap bit makes the pointer difference an exact occupancy count.
    assign tx_count = tx_wr_q - tx_rd_q;
    assign rx_count = rx_wr_q - rx_rd_q;
    assign tx_full  = (tx_count == TX_FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == RX_FULL_CNT);
    assign rx_empty = (rx_count == '0);
    assign tx_head  = tx_mem[tx_rd_q[TX_AW-1:0]];
    assign rx_head  = rx_mem[rx_rd_q[RX_AW-1:0]];

    // Read channel: response registered one cycle after the address handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        r_state_d     = r_state_q;
        r_id_d        = r_id_q;
        r_data_d      = r_data_q;
        r_resp_d      = r_resp_q;
        r_last_d      = r_last_q;
        r_valid_d     = r_valid_q;
        r_beats_d     = r_beats_q;
        rx_pop_pend_d = rx_pop_pend_q;
        rx_pop        = 1'b0;
        ar_ready      = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (ar_valid) begin
                    r_state_d     = R_DATA;
                    r_valid_d     = 1'b1;
                    r_id_d        = ar_id;
                    r_beats_d     = ar_len;
                    r_last_d      = (ar_len == 8'd0);
                    r_resp_d      = 2'b00;
                    r_data_d      = '0;
                    rx_pop_pend_d = 1'b0;
                    if (ar_addr[3:0] == DATA_OFS) begin
                        if (!rx_empty) begin
                            r_data_d      = {24'b0, rx_head};
                            rx_pop_pend_d = 1'b1;
                        end
                    end else if (ar_addr[3:0] == STAT_OFS) begin
                        r_data_d = {30'b0, !rx_empty, !tx_full};
                    end else begin
                        r_resp_d = 2'b10;
                    end
                end
            end
            R_DATA: begin
                if (r_ready) begin
                    rx_pop        = rx_pop_pend_q;
                    rx_pop_pend_d = 1'b0;
                    if (r_last_q) begin
                        r_state_d = R_IDLE;
                        r_valid_d = 1'b0;
                        r_last_d  = 1'b0;
                    end else begin
                        r_beats_d = r_beats_q - 1'b1;
                        r_last_d  = (r_beats_q == 8'd1);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_ofs_d   = w_ofs_q;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        b_resp    = 2'b00;
        tx_push   = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                aw_ready = 1'b1;
                if (aw_valid) begin
                    w_state_d = W_DATA;
                    w_id_d    = aw_id;
                    w_ofs_d   = aw_addr[3:0];
                end
            end
            W_DATA: begin
                w_ready = !((w_ofs_q == DATA_OFS) && tx_full);
                if (w_valid && w_ready) begin
                    tx_push = (w_ofs_q == DATA_OFS) && w_strb[0];
                    if (w_last) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                b_valid = 1'b1;
                b_resp  = is_mapped(w_ofs_q) ? 2'b00 : 2'b10;
                if (b_ready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Serial side: the previous-cycle pulse blocks a repeat while the PHY status catches up.
    always_comb begin
        tx_pop     = !tx_empty && !tx_busy && !tx_start_q;
        tx_start_d = tx_pop;
        tx_data_d  = tx_pop ? tx_head : tx_data_q;
        rx_push    = rx_ready && !rx_full && !rx_clear_q;
        rx_clear_d = rx_push;

        tx_wr_d = tx_push ? tx_wr_q + 1'b1 : tx_wr_q;
        tx_rd_d = tx_pop  ? tx_rd_q + 1'b1 : tx_rd_q;
        rx_wr_d = rx_push ? rx_wr_q + 1'b1 : rx_wr_q;
        rx_rd_d = rx_pop  ? rx_rd_q + 1'b1 : rx_rd_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= R_IDLE;
            r_id_q        <= '0;
            r_data_q      <= '0;
            r_resp_q      <= '0;
            r_last_q      <= 1'b0;
            r_valid_q     <= 1'b0;
            r_beats_q     <= '0;
            rx_pop_pend_q <= 1'b0;
            w_state_q     <= W_IDLE;
            w_id_q        <= '0;
            w_ofs_q       <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            rx_clear_q    <= 1'b0;
            tx_wr_q       <= '0;
            tx_rd_q       <= '0;
            rx_wr_q       <= '0;
            rx_rd_q       <= '0;
        end else begin
            r_state_q     <= r_state_d;
            r_id_q        <= r_id_d;
            r_data_q      <= r_data_d;
            r_resp_q      <= r_resp_d;
            r_last_q      <= r_last_d;
            r_valid_q     <= r_valid_d;
            r_beats_q     <= r_beats_d;
            rx_pop_pend_q <= rx_pop_pend_d;
            w_state_q     <= w_state_d;
            w_id_q        <= w_id_d;
            w_ofs_q       <= w_ofs_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            rx_clear_q    <= rx_clear_d;
            tx_wr_q       <= tx_wr_d;
            tx_rd_q       <= tx_rd_d;
            rx_wr_q       <= rx_wr_d;
            rx_rd_q       <= rx_rd_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q[TX_AW-1:0]] <= w_data[7:0];
        if (rx_push) rx_mem[rx_wr_q[RX_AW-1:0]] <= rx_data;
    end

    assign r_id     = r_id_q;
    assign r_data   = r_data_q;
    assign r_resp   = r_resp_q;
    assign r_last   = r_last_q;
    assign r_valid  = r_valid_q;
    assign b_id     = w_id_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign rx_clear = rx_clear_q;

    logic unused_bits;
    assign unused_bits = ^{ar_size, ar_burst, ar_addr[31:4], aw_size, aw_burst,
                           aw_addr[31:4], aw_len, w_data[31:8], w_strb[3:1]};

endmodule
